sw_input_port: RTL and testbench

- Receiving end of the switch stimulus path: captures the byte on SW[7:0] when the operator or bench presses SW[8], and presents it to the picoMIPS core as a read port.
- SW[8] is the strobe and is synchronised and debounced before use.
- Captured data is held until the core acknowledges it; each press yields exactly one word.
- Sits between the top-level SW pins and the core's input-port mux, alongside the LED output register.

---
 rtl/sw_input_port.sv | 122 ++++++++++++
 tb/tb_sw_input_port.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sw_input_port.sv
// Switch input port: synchronises and debounces the SW[8] strobe, captures the
// SW[7:0] byte on each accepted press and holds it for the core until acknowledged.
module sw_input_port #(
  parameter int DATA_W          = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              fastclk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              sw_strobe,
  input  logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              overrun
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FULL,
    WAIT_REL
  } state_t;

  logic [DATA_W-1:0] data_s1, data_s2;
  logic              strobe_s1, strobe_s2;
  logic              db;
  logic [CNT_W-1:0]  cnt;
  state_t            state, next_state;
  logic              db_next;
  logic              press;
  logic              capture;
  logic              set_overrun;

  // Two-flop synchronisers for every switch input.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge fastclk) begin
    if (reset) begin
      data_s1   <= '0;
      data_s2   <= '0;
      strobe_s1 <= 1'b0;
      strobe_s2 <= 1'b0;
    end else begin
      data_s1   <= sw_data;
      data_s2   <= data_s1;
      strobe_s1 <= sw_strobe;
      strobe_s2 <= strobe_s1;
    end
  end

  // Debounce: the accepted level only follows s2 after it has disagreed for
  // DEBOUNCE_CYCLES consecutive cycles; cnt never exceeds CNT_MAX.
  always_ff @(posedge fastclk) begin
    if (reset) begin
      db  <= 1'b0;
      cnt <= '0;
    end else if (strobe_s2 == db) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      db  <= strobe_s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Press and the post-edge debounced level are decoded combinationally so the
  // FSM reacts on the very edge db changes.
  assign db_next = (strobe_s2 != db && cnt == CNT_MAX) ? strobe_s2 : db;
  assign press   = !db && db_next;

  // NOTE: every always_comb output gets a default first so no path can leave a
  // signal unassigned and infer a latch.
  always_comb begin
    next_state  = state;
    capture     = 1'b0;
    set_overrun = 1'b0;
    unique case (state)
      IDLE: begin
        if (press) begin
          next_state = FULL;
          capture    = 1'b1;
        end
      end
      FULL: begin
        // Ack takes priority; a press on the same edge is simply dropped.
        if (rd_ack) begin
          next_state = db_next ? WAIT_REL : IDLE;
        end else if (press) begin
          set_overrun = 1'b1;
        end
      end
      WAIT_REL: begin
        if (!db_next) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge fastclk) begin
    if (reset) begin
      state   <= IDLE;
      rd_data <= '0;
      overrun <= 1'b0;
    end else begin
      state <= next_state;
      if (capture) begin
        rd_data <= data_s2;
      end
      if (set_overrun) begin
        overrun <= 1'b1;
      end
    end
  end

  assign rd_valid = (state == FULL);

endmodule

// File: tb/tb_sw_input_port.sv
// Testbench for sw_input_port: directed switch stimulus with a scoreboard queue of
// expected captured words checked by an independent monitor on each rd_valid rise.
module tb_sw_input_port;

  localparam int DATA_W = 8;
  localparam int DEBOUNCE_CYCLES = 4;

  logic              fastclk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] sw_data = '0;
  logic              sw_strobe = 1'b0;
  logic              rd_ack = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              overrun;

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic prev_valid = 1'b0;

  sw_input_port #(
    .DATA_W(DATA_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .fastclk  (fastclk),
    .reset    (reset),
    .sw_data  (sw_data),
    .sw_strobe(sw_strobe),
    .rd_ack   (rd_ack),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .overrun  (overrun)
  );

  always #10 fastclk = ~fastclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every new rd_valid must correspond to a queued expected word.
  always @(negedge fastclk) begin
    if (rd_valid && !prev_valid) begin
      check("capture_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [DATA_W-1:0] exp_word;
        exp_word = exp_q.pop_front();
        check("captured_word", 32'(rd_data), 32'(exp_word));
      end
    end
    prev_valid = rd_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge fastclk);
      #1;
    end
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
  endtask

  task automatic release_sw();
    sw_strobe = 1'b0;
    tick(6);
  endtask

  // Press with stable data; rd_valid must rise exactly DEBOUNCE_CYCLES+1 edges
  // after the first edge that samples the strobe high.
  task automatic capture(input logic [DATA_W-1:0] d, input string name);
    sw_data = d;
    tick(3);
    sw_strobe = 1'b1;
    exp_q.push_back(d);
    tick(5);
    check({name, "_not_early"}, 32'(rd_valid), 32'd0);
    tick(1);
    check({name, "_valid"}, 32'(rd_valid), 32'd1);
  endtask

  initial begin
    tick(3);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    tick(2);

    // Glitches shorter than the debounce window.
    for (int len = 2; len <= 3; len++) begin
      sw_strobe = 1'b1;
      tick(len);
      sw_strobe = 1'b0;
      tick(8);
      check($sformatf("glitch%0d_no_valid", len), 32'(rd_valid), 32'd0);
      check($sformatf("glitch%0d_db_low", len), 32'(dut.db), 32'd0);
    end

    capture(8'hA5, "cap_a5");
    ack();
    check("ack_clears_valid", 32'(rd_valid), 32'd0);
    tick(8);
    check("held_no_recapture", 32'(rd_valid), 32'd0);
    release_sw();
    capture(8'h3C, "cap_3c");
    ack();
    release_sw();

    // Second press before ack sets overrun; first word is kept.
    capture(8'h11, "cap_11");
    sw_strobe = 1'b0;
    sw_data = 8'h22;
    tick(6);
    sw_strobe = 1'b1;
    tick(5);
    check("overrun_not_early", 32'(overrun), 32'd0);
    tick(1);
    check("overrun_set", 32'(overrun), 32'd1);
    check("first_word_wins", 32'(rd_data), 32'h11);
    check("still_valid", 32'(rd_valid), 32'd1);
    ack();
    check("ack_after_overrun", 32'(rd_valid), 32'd0);
    release_sw();
    capture(8'h22, "cap_22");
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset while FULL with strobe held high through it.
    reset = 1'b1;
    tick(1);
    check("midreset_rd_valid", 32'(rd_valid), 32'd0);
    check("midreset_rd_data", 32'(rd_data), 32'd0);
    check("midreset_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    exp_q.push_back(8'h22);
    tick(5);
    check("recap_not_early", 32'(rd_valid), 32'd0);
    tick(1);
    check("recap_valid", 32'(rd_valid), 32'd1);

    // Ack and press on the same edge: ack wins, press dropped, no overrun.
    sw_data = 8'h5A;
    release_sw();
    sw_strobe = 1'b1;
    tick(5);
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    check("ack_beats_press", 32'(rd_valid), 32'd0);
    check("dropped_press_no_overrun", 32'(overrun), 32'd0);
    tick(8);
    check("wait_rel_after_collision", 32'(rd_valid), 32'd0);
    release_sw();

    // Ack in IDLE is ignored.
    ack();
    tick(3);
    check("idle_ack_no_valid", 32'(rd_valid), 32'd0);
    check("idle_ack_no_overrun", 32'(overrun), 32'd0);

    capture(8'h96, "cap_96");
    ack();
    release_sw();
    tick(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
